// File: rtl/bitop_alu_pipe.sv
// Two-stage pipelined bit-manipulation ALU: parity, popcount, rotates, CLZ/CTZ, bit-reverse.
// Valid/ready on both sides, tag passthrough, reserved opcode flagged through out_err.
module bitop_alu_pipe #(
  parameter int DATA_WIDTH = 512,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            opcode,
  input  logic [DATA_WIDTH-1:0] A_in,
  input  logic [DATA_WIDTH-1:0] B_in,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Alu_out,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  out_err
);

  localparam int SH_W  = $clog2(DATA_WIDTH);
  localparam int CNT_W = SH_W + 1;

  localparam logic [2:0] OP_PARITY = 3'd0;
  localparam logic [2:0] OP_POPCNT = 3'd1;
  localparam logic [2:0] OP_ROTR   = 3'd2;
  localparam logic [2:0] OP_ROTL   = 3'd3;
  localparam logic [2:0] OP_CLZ    = 3'd4;
  localparam logic [2:0] OP_CTZ    = 3'd5;
  localparam logic [2:0] OP_BREV   = 3'd6;

  function automatic logic [CNT_W-1:0] f_popcount(input logic [DATA_WIDTH-1:0] a);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < DATA_WIDTH; i++) cnt = cnt + CNT_W'(a[i]);
    return cnt;
  endfunction

  // The highest set bit is the last one to write, so it wins.
  function automatic logic [CNT_W-1:0] f_clz(input logic [DATA_WIDTH-1:0] a);
    logic [CNT_W-1:0] cnt;
    cnt = CNT_W'(DATA_WIDTH);
    for (int i = 0; i < DATA_WIDTH; i++)
      if (a[i]) cnt = CNT_W'(DATA_WIDTH - 1 - i);
    return cnt;
  endfunction

  function automatic logic [CNT_W-1:0] f_ctz(input logic [DATA_WIDTH-1:0] a);
    logic [CNT_W-1:0] cnt;
    cnt = CNT_W'(DATA_WIDTH);
    for (int i = DATA_WIDTH - 1; i >= 0; i--)
      if (a[i]) cnt = CNT_W'(i);
    return cnt;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] f_brev(input logic [DATA_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] r;
    for (int i = 0; i < DATA_WIDTH; i++) r[i] = a[DATA_WIDTH-1-i];
    return r;
  endfunction

  // Rotates shift a doubled copy so wrapped bits fall into the kept half.
  function automatic logic [DATA_WIDTH-1:0] f_rotr(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [SH_W-1:0] k);
    logic [2*DATA_WIDTH-1:0] dbl;
    dbl = {a, a} >> k;
    return dbl[DATA_WIDTH-1:0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] f_rotl(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [SH_W-1:0] k);
    logic [2*DATA_WIDTH-1:0] dbl;
    dbl = {a, a} << k;
    return dbl[2*DATA_WIDTH-1:DATA_WIDTH];
  endfunction

  logic                  rdy_en;
  logic                  vld_p1;
  logic [2:0]            op_p1;
  logic [DATA_WIDTH-1:0] a_p1;
  logic [SH_W-1:0]       k_p1;
  logic [TAG_WIDTH-1:0]  tag_p1;
  logic [DATA_WIDTH-1:0] res_p1;
  logic                  err_p1;
  logic                  advance;
  logic                  unused_b;

  assign unused_b = ^B_in[DATA_WIDTH-1:SH_W];
  assign advance  = !out_valid || out_ready;
  assign in_ready = rdy_en && (!vld_p1 || advance);

  // ---- stage 1: operand capture ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_en <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (in_ready) vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      op_p1  <= opcode;
      a_p1   <= A_in;
      k_p1   <= B_in[SH_W-1:0];
      tag_p1 <= in_tag;
    end
  end

  always_comb begin
    res_p1 = '0;
    err_p1 = 1'b0;
    case (op_p1)
      OP_PARITY: res_p1[0] = ^a_p1;
      OP_POPCNT: res_p1 = DATA_WIDTH'(f_popcount(a_p1));
      OP_ROTR:   res_p1 = f_rotr(a_p1, k_p1);
      OP_ROTL:   res_p1 = f_rotl(a_p1, k_p1);
      OP_CLZ:    res_p1 = DATA_WIDTH'(f_clz(a_p1));
      OP_CTZ:    res_p1 = DATA_WIDTH'(f_ctz(a_p1));
      OP_BREV:   res_p1 = f_brev(a_p1);
      default:   err_p1 = 1'b1;
    endcase
  end

  // ---- stage 2: result register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      Alu_out   <= '0;
      out_tag   <= '0;
      out_err   <= 1'b0;
    end else if (advance) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        Alu_out <= res_p1;
        out_tag <= tag_p1;
        out_err <= err_p1;
      end
    end
  end

  a_in_stable: assert property (@(posedge clk) disable iff (rst)
    (in_valid && !in_ready) |=> (in_valid && $stable(opcode) && $stable(A_in)
                                 && $stable(B_in) && $stable(in_tag)));

endmodule

// File: tb/tb_bitop_alu_pipe.sv
// Bench for bitop_alu_pipe at DATA_WIDTH=8 (directed table, backpressure, throughput, reset)
// and at DATA_WIDTH=512 (random stream), all results scored against a behavioural model.
module tb_bitop_alu_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       iv8, ir8, ov8, or8, oerr8;
  logic [2:0] op8;
  logic [7:0] a8, b8, res8;
  logic [3:0] tg8, otg8;

  logic         iv5, ir5, ov5, or5, oerr5;
  logic [2:0]   op5;
  logic [511:0] a5, b5, res5;
  logic [3:0]   tg5, otg5;

  bitop_alu_pipe #(.DATA_WIDTH(8), .TAG_WIDTH(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .opcode(op8),
    .A_in(a8), .B_in(b8), .in_tag(tg8), .out_valid(ov8), .out_ready(or8),
    .Alu_out(res8), .out_tag(otg8), .out_err(oerr8));

  bitop_alu_pipe dut512 (
    .clk(clk), .rst(rst), .in_valid(iv5), .in_ready(ir5), .opcode(op5),
    .A_in(a5), .B_in(b5), .in_tag(tg5), .out_valid(ov5), .out_ready(or5),
    .Alu_out(res5), .out_tag(otg5), .out_err(oerr5));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chkw(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: each op computed directly from its definition on an n-bit operand.
  function automatic logic [511:0] model(input int n, input logic [2:0] op,
                                         input logic [511:0] a, input logic [511:0] b);
    logic [511:0] r;
    int k, cnt;
    r   = '0;
    cnt = 0;
    k   = int'(b[15:0]) % n;
    for (int i = 0; i < n; i++) cnt += int'(a[i]);
    case (op)
      3'd0: r[0] = cnt[0];
      3'd1: r = 512'(cnt);
      3'd2: for (int i = 0; i < n; i++) r[i] = a[(i + k) % n];
      3'd3: for (int i = 0; i < n; i++) r[(i + k) % n] = a[i];
      3'd4: begin
        cnt = 0;
        while (cnt < n && a[n-1-cnt] == 1'b0) cnt++;
        r = 512'(cnt);
      end
      3'd5: begin
        cnt = 0;
        while (cnt < n && a[cnt] == 1'b0) cnt++;
        r = 512'(cnt);
      end
      3'd6: for (int i = 0; i < n; i++) r[i] = a[n-1-i];
      default: r = '0;
    endcase
    return r;
  endfunction

  typedef struct {
    logic [511:0] res;
    logic [3:0]   tag;
    logic         err;
  } exp_t;

  exp_t         q8[$];
  exp_t         q512[$];
  logic [511:0] prev_res[2];
  logic [3:0]   prev_tag[2];
  logic         prev_err[2];
  logic         prev_stall[2];
  int           retired[2];
  logic         chk_rdy;

  // Scoreboard step for one DUT, evaluated between clock edges.
  task automatic mon(input int id, input int n, input logic iv, input logic ir,
                     input logic ov, input logic ordy, input logic [2:0] op,
                     input logic [511:0] a, input logic [511:0] b, input logic [511:0] res,
                     input logic [3:0] itg, input logic [3:0] otg, input logic oerr);
    exp_t e;
    int   depth;
    if (rst) begin
      if (id == 0) q8.delete(); else q512.delete();
      prev_stall[id] = 1'b0;
      return;
    end
    depth = (id == 0) ? q8.size() : q512.size();
    if (chk_rdy) chk1($sformatf("in_ready_w%0d", n), ir, !(depth == 2 && !ordy));
    if (prev_stall[id]) begin
      chk1($sformatf("hold_valid_w%0d", n), ov, 1'b1);
      chkw($sformatf("hold_res_w%0d", n), res, prev_res[id]);
      chkw($sformatf("hold_tag_w%0d", n), 512'(otg), 512'(prev_tag[id]));
      chk1($sformatf("hold_err_w%0d", n), oerr, prev_err[id]);
    end
    if (ov && ordy) begin
      if (depth == 0) begin
        chki($sformatf("spurious_result_w%0d", n), 1, 0);
      end else begin
        if (id == 0) e = q8.pop_front(); else e = q512.pop_front();
        chkw($sformatf("result_w%0d", n), res, e.res);
        chkw($sformatf("tag_w%0d", n), 512'(otg), 512'(e.tag));
        chk1($sformatf("err_w%0d", n), oerr, e.err);
        retired[id]++;
      end
    end
    if (iv && ir) begin
      e.res = model(n, op, a, b);
      e.tag = itg;
      e.err = (op == 3'b111);
      if (id == 0) q8.push_back(e); else q512.push_back(e);
    end
    prev_stall[id] = ov && !ordy;
    prev_res[id]   = res;
    prev_tag[id]   = otg;
    prev_err[id]   = oerr;
  endtask

  always @(negedge clk)
    mon(0, 8, iv8, ir8, ov8, or8, op8, 512'(a8), 512'(b8), 512'(res8), tg8, otg8, oerr8);
  always @(negedge clk)
    mon(1, 512, iv5, ir5, ov5, or5, op5, a5, b5, res5, tg5, otg5, oerr5);

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] tag;
    logic [7:0] res;
    logic       err;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] tag, input logic [7:0] res, input logic err,
                         input string name);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.tag = tag; v.res = res; v.err = err; v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int   r0, guard, sel;
    logic acc;

    add_vec(3'd1, 8'hB5, 8'h00, 4'h1, 8'h05, 1'b0, "popcnt_b5");
    add_vec(3'd0, 8'hB5, 8'h00, 4'h2, 8'h01, 1'b0, "parity_b5");
    add_vec(3'd0, 8'h03, 8'h00, 4'h3, 8'h00, 1'b0, "parity_03");
    add_vec(3'd4, 8'h10, 8'h00, 4'h3, 8'h03, 1'b0, "clz_10");
    add_vec(3'd5, 8'h10, 8'h00, 4'h4, 8'h04, 1'b0, "ctz_10");
    add_vec(3'd6, 8'h01, 8'h00, 4'h5, 8'h80, 1'b0, "brev_01");
    add_vec(3'd6, 8'hD2, 8'h00, 4'h6, 8'h4B, 1'b0, "brev_d2");
    add_vec(3'd2, 8'h81, 8'h01, 4'h6, 8'hC0, 1'b0, "rotr_81_1");
    add_vec(3'd3, 8'h81, 8'h09, 4'h7, 8'h03, 1'b0, "rotl_81_9");
    add_vec(3'd3, 8'h81, 8'h08, 4'h8, 8'h81, 1'b0, "rotl_81_8");
    add_vec(3'd2, 8'h81, 8'h08, 4'h9, 8'h81, 1'b0, "rotr_81_8");
    add_vec(3'd2, 8'h12, 8'h04, 4'hA, 8'h21, 1'b0, "rotr_12_4");
    add_vec(3'd4, 8'h00, 8'h00, 4'hB, 8'h08, 1'b0, "clz_zero");
    add_vec(3'd5, 8'h00, 8'h00, 4'hC, 8'h08, 1'b0, "ctz_zero");
    add_vec(3'd1, 8'hFF, 8'h00, 4'hD, 8'h08, 1'b0, "popcnt_ff");
    add_vec(3'd4, 8'h80, 8'h00, 4'hE, 8'h00, 1'b0, "clz_80");
    add_vec(3'd5, 8'h80, 8'h00, 4'hF, 8'h07, 1'b0, "ctz_80");
    add_vec(3'd7, 8'hFF, 8'h3C, 4'h5, 8'h00, 1'b1, "reserved_op");

    rst = 1'b1; chk_rdy = 1'b0;
    iv8 = 1'b0; or8 = 1'b1; op8 = '0; a8 = '0; b8 = '0; tg8 = '0;
    iv5 = 1'b0; or5 = 1'b1; op5 = '0; a5 = '0; b5 = '0; tg5 = '0;
    retired[0] = 0; retired[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_out_valid8", ov8, 1'b0);
    chkw("rst_alu_out8", 512'(res8), '0);
    chkw("rst_out_tag8", 512'(otg8), '0);
    chk1("rst_out_err8", oerr8, 1'b0);
    chk1("rst_out_valid512", ov5, 1'b0);
    chkw("rst_alu_out512", res5, '0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk1("rdy_after_rst8", ir8, 1'b1);
    chk1("rdy_after_rst512", ir5, 1'b1);
    chk_rdy = 1'b1;

    // Directed vectors at W=8 with latency checked edge by edge.
    foreach (vecs[i]) begin
      op8 = vecs[i].op; a8 = vecs[i].a; b8 = vecs[i].b; tg8 = vecs[i].tag; iv8 = 1'b1;
      @(posedge clk); #1;
      iv8 = 1'b0;
      chk1({vecs[i].name, "_early"}, ov8, 1'b0);
      @(posedge clk); #1;
      chk1({vecs[i].name, "_valid"}, ov8, 1'b1);
      chkw({vecs[i].name, "_res"}, 512'(res8), 512'(vecs[i].res));
      chkw({vecs[i].name, "_tag"}, 512'(otg8), 512'(vecs[i].tag));
      chk1({vecs[i].name, "_err"}, oerr8, vecs[i].err);
    end
    @(posedge clk); #1;

    // Backpressure: ten tagged requests against a random consumer.
    r0 = retired[0];
    or8 = 1'($urandom_range(0, 1));
    for (int t = 0; t < 10; t++) begin
      op8 = 3'($urandom_range(0, 7)); a8 = 8'($urandom); b8 = 8'($urandom);
      tg8 = 4'(t); iv8 = 1'b1;
      guard = 0; acc = 1'b0;
      while (!acc && guard < 64) begin
        @(negedge clk); acc = ir8;
        @(posedge clk); #1;
        or8 = 1'($urandom_range(0, 1));
        guard++;
      end
      chk1("t5_accept", acc, 1'b1);
    end
    iv8 = 1'b0; or8 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chki("t5_retired", retired[0] - r0, 10);
    chki("t5_drained", q8.size(), 0);

    // Throughput: one request per cycle for 100 cycles.
    r0 = retired[0];
    for (int t = 0; t < 100; t++) begin
      op8 = 3'($urandom_range(0, 7)); a8 = 8'($urandom); b8 = 8'($urandom);
      tg8 = 4'(t); iv8 = 1'b1;
      @(negedge clk);
      chk1("t6_in_ready", ir8, 1'b1);
      if (t >= 2) chk1("t6_out_valid", ov8, 1'b1);
      @(posedge clk); #1;
    end
    iv8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chki("t6_results", retired[0] - r0, 100);

    // Reset with two requests in flight.
    or8 = 1'b0;
    op8 = 3'd1; a8 = 8'hFF; b8 = 8'h00; tg8 = 4'h1; iv8 = 1'b1;
    @(posedge clk); #1;
    op8 = 3'd6; a8 = 8'h0F; tg8 = 4'h2;
    @(posedge clk); #1;
    iv8 = 1'b0;
    chk1("t1_full_ready", ir8, 1'b0);
    chk1("t1_full_valid", ov8, 1'b1);
    rst = 1'b1; chk_rdy = 1'b0;
    #1;
    chk1("t1_rst_valid", ov8, 1'b0);
    chkw("t1_rst_res", 512'(res8), '0);
    chkw("t1_rst_tag", 512'(otg8), '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; or8 = 1'b1;
    @(posedge clk); #1;
    chk1("t1_rdy_release", ir8, 1'b1);
    chk_rdy = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      chk1("t1_no_stale", ov8, 1'b0);
    end

    // Random stream at W=512 with corner-case operands mixed in.
    r0 = retired[1];
    for (int t = 0; t < 150; t++) begin
      sel = $urandom_range(0, 5);
      for (int w = 0; w < 16; w++) a5[w*32 +: 32] = $urandom;
      if (sel == 0) a5 = '0;
      else if (sel == 1) a5 = '1;
      else if (sel == 2) a5 = 512'(1) << $urandom_range(0, 511);
      for (int w = 0; w < 16; w++) b5[w*32 +: 32] = $urandom;
      if ($urandom_range(0, 7) == 0) b5 = 512'(512);
      op5 = 3'($urandom_range(0, 7)); tg5 = 4'($urandom); iv5 = 1'b1;
      guard = 0; acc = 1'b0;
      while (!acc && guard < 64) begin
        @(negedge clk); acc = ir5;
        @(posedge clk); #1;
        or5 = ($urandom_range(0, 3) != 0);
        guard++;
      end
      chk1("w512_accept", acc, 1'b1);
    end
    iv5 = 1'b0; or5 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chki("w512_retired", retired[1] - r0, 150);
    chki("w512_drained", q512.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
